// File: rtl/chameleon_usart_rx_if.sv
// CPU-side bundle of the Chameleon USART receiver: the show-ahead FIFO head
// with its pop handshake, the occupancy, and the status/error flags.
// master = receiver block, slave = consumer (cfide register side).
interface chameleon_usart_rx_if #(
  parameter int FIFO_AW = 2
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic [FIFO_AW:0] fill;
  logic             busy;
  logic             frame_err;
  logic             overflow;
  logic             err_clr;

  modport master (
    output rx_data, rx_valid, fill, busy, frame_err, overflow,
    input  rx_ack, err_clr
  );

  modport slave (
    input  rx_data, rx_valid, fill, busy, frame_err, overflow,
    output rx_ack, err_clr
  );
endinterface

// File: rtl/chameleon_usart_rx.sv
// Chameleon MCU -> FPGA synchronous serial receiver.
// Both serial pins are synchronized into clk; the deframer acts only on the
// synced rising edge of the MCU clock, deframes 8N1 characters LSB-first and
// queues good bytes in a small show-ahead FIFO. A held-low line after a bad
// stop bit is parked in BREAK so it cannot produce phantom frames.
module chameleon_usart_rx #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_clk,
  input  logic                  serial_rxd,
  chameleon_usart_rx_if.master  bus
);

  localparam int               TW      = $clog2(TIMEOUT + 1);
  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [TW-1:0]    TMO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0]    TMO_ONE = TW'(1);
  localparam logic [FIFO_AW:0] CNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] CNT_ZERO = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  // synchronizers and edge detect
  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic rxd_meta_r, rxd_sync_r;
  logic sclk_rise_s;

  // deframer
  state_t        state_r, next_s;
  logic [7:0]    shreg_r;
  logic [2:0]    bit_cnt_r;
  logic [TW-1:0] tmo_r;
  logic          timeout_s;
  logic          shift_s, cnt_clr_s, push_s, ferr_set_s;
  logic          busy_r;

  // FIFO
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r, count_next_s;
  logic               full_s, pop_s, wr_s, ovf_set_s;
  logic               rx_valid_r;

  // flags
  logic frame_err_r, overflow_r;

  // Two-stage synchronizers on both pins plus a history stage on the clock; idle line is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_prev_r <= 1'b1;
      rxd_meta_r  <= 1'b1;
      rxd_sync_r  <= 1'b1;
    end else begin
      sclk_meta_r <= serial_clk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      rxd_meta_r  <= serial_rxd;
      rxd_sync_r  <= rxd_meta_r;
    end
  end

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign timeout_s   = (state_r != ST_IDLE) && (tmo_r == TMO_MAX);

  // Deframer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Deframer next state and per-edge actions; a timeout overrides any edge in the same cycle.
  always_comb begin
    next_s     = state_r;
    shift_s    = 1'b0;
    cnt_clr_s  = 1'b0;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    if (timeout_s) begin
      next_s     = ST_IDLE;
      ferr_set_s = 1'b1;
    end else if (sclk_rise_s) begin
      case (state_r)
        ST_IDLE: begin
          if (rxd_sync_r == 1'b0) begin
            next_s    = ST_DATA;
            cnt_clr_s = 1'b1;
          end else begin
            next_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            next_s = ST_STOP;
          end else begin
            next_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (rxd_sync_r == 1'b1) begin
            push_s = 1'b1;
            next_s = ST_IDLE;
          end else begin
            ferr_set_s = 1'b1;
            next_s     = ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rxd_sync_r == 1'b1) begin
            next_s = ST_IDLE;
          end else begin
            next_s = ST_BREAK;
          end
        end
        default: begin
          next_s = ST_IDLE;
        end
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // Shift register (LSB first), bit counter and busy indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (next_s != ST_IDLE);
      if (cnt_clr_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_s) begin
        shreg_r   <= {rxd_sync_r, shreg_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Inter-edge watchdog: restarts on every serial edge, saturates at TIMEOUT, idle keeps it at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_r <= '0;
    end else if ((state_r == ST_IDLE) || sclk_rise_s || timeout_s) begin
      tmo_r <= '0;
    end else if (tmo_r != TMO_MAX) begin
      tmo_r <= tmo_r + TMO_ONE;
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    full_s    = (count_r == CNT_MAX);
    pop_s     = bus.rx_ack && (count_r != CNT_ZERO);
    wr_s      = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    case ({wr_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are not reset and only meaningful below count.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= shreg_r;
    end
  end

  // FIFO pointers, occupancy and registered valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rx_valid_r <= 1'b0;
    end else begin
      count_r    <= count_next_s;
      rx_valid_r <= (count_next_s != CNT_ZERO);
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (ferr_set_s) begin
        frame_err_r <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err_r <= 1'b0;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = mem_r[rd_ptr_r];
  assign bus.rx_valid  = rx_valid_r;
  assign bus.fill      = count_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Bench for chameleon_usart_rx: table of single frames plus hand-written
// sequences for overflow, push/pop at full, timeout and mid-frame reset.
// A byte queue holds what the FIFO must contain; it is updated as frames
// are driven and compared when bytes are popped.
module tb_chameleon_usart_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_clk = 1'b1;
  logic serial_rxd = 1'b1;

  chameleon_usart_rx_if #(.FIFO_AW(2)) bus ();

  chameleon_usart_rx #(.FIFO_AW(2), .TIMEOUT(1023)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_clk (serial_clk),
    .serial_rxd (serial_rxd),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One serial bit, 8 clk low then 8 clk high; optionally pulse rx_ack on the acting edge.
  task automatic send_bit(input logic b, input logic ack_here);
    serial_clk = 1'b0;
    serial_rxd = b;
    repeat (8) @(negedge clk);
    serial_clk = 1'b1;
    if (ack_here) begin
      @(negedge clk);
      @(negedge clk);
      check("head_at_push", {24'd0, bus.rx_data}, {24'd0, exp_q[0]});
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  // Full frame; the model queue tracks only good-stop frames and FIFO capacity.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(stop, ack_at_stop);
    if (stop) begin
      if (ack_at_stop) begin
        void'(exp_q.pop_front());
        exp_q.push_back(d);
      end else if (exp_q.size() < 4) begin
        exp_q.push_back(d);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      check("valid_before_pop", {31'd0, bus.rx_valid}, 32'd1);
      check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q[0]});
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
      void'(exp_q.pop_front());
    end
    check("valid_after_drain", {31'd0, bus.rx_valid}, 32'd0);
    check("fill_after_drain", {29'd0, bus.fill}, 32'd0);
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_err: 1'b1};
    vecs[2] = '{data: 8'h55, stop: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_err: 1'b0};

    bus.rx_ack  = 1'b0;
    bus.err_clr = 1'b0;
    exp_ovf     = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_fill", {29'd0, bus.fill}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);

    // table: single frames, good and bad stop bit
    for (int v = 0; v < 5; v++) begin
      clear_errs();
      check("err_clr", {31'd0, bus.frame_err}, 32'd0);
      send_frame(vecs[v].data, vecs[v].stop, 1'b0);
      if (!vecs[v].stop) begin
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (2) @(negedge clk);
      end
      check("vec_frame_err", {31'd0, bus.frame_err}, {31'd0, vecs[v].exp_err});
      check("vec_fill", {29'd0, bus.fill}, exp_q.size());
      drain();
    end

    // overflow: five bytes, no pops
    clear_errs();
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0);
      check("ovf_fill", {29'd0, bus.fill}, exp_q.size());
      check("ovf_flag", {31'd0, bus.overflow}, {31'd0, exp_ovf});
    end
    drain();

    // push and pop in the same cycle while full
    clear_errs();
    for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1, 1'b0);
    check("full_fill", {29'd0, bus.fill}, 32'd4);
    send_frame(8'h14, 1'b1, 1'b1);
    check("pp_fill", {29'd0, bus.fill}, 32'd4);
    check("pp_overflow", {31'd0, bus.overflow}, 32'd0);
    drain();

    // timeout after start + 3 data bits
    clear_errs();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (990) @(negedge clk);
    check("tmo_early_err", {31'd0, bus.frame_err}, 32'd0);
    check("tmo_early_busy", {31'd0, bus.busy}, 32'd1);
    repeat (100) @(negedge clk);
    check("tmo_err", {31'd0, bus.frame_err}, 32'd1);
    check("tmo_busy", {31'd0, bus.busy}, 32'd0);
    check("tmo_fill", {29'd0, bus.fill}, 32'd0);
    clear_errs();
    send_frame(8'h7E, 1'b1, 1'b0);
    check("tmo_next_fill", {29'd0, bus.fill}, exp_q.size());
    drain();

    // reset in the middle of a frame with bytes queued
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'hBB, 1'b1, 1'b0);
    check("mr_fill", {29'd0, bus.fill}, 32'd2);
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(k[0], 1'b0);
    check("mr_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mr_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mr_fill0", {29'd0, bus.fill}, 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("mr_overflow", {31'd0, bus.overflow}, 32'd0);
    serial_rxd = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("mr_next_fill", {29'd0, bus.fill}, 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/chameleon_usart_rx.md
# chameleon_usart_rx

Synchronous serial receiver for the link from the Chameleon microcontroller to the FPGA. It is the inbound counterpart of the reconfigure/command transmitter that drives `usart_rx`. The block samples the MCU-driven data line (`usart_tx` pin) on rising edges of the MCU-supplied `usart_clk`, deframes 8N1 characters and queues them in a small show-ahead FIFO for the control CPU (cfide register side). It runs entirely in the `sysclk` domain; both serial pins are asynchronous inputs.

## Interface
- `FIFO_AW`, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).
- `TIMEOUT`, 1023, `clk` cycles allowed between serial clock edges inside a frame before the frame is aborted.

- `clk`  in  1  system clock (`sysclk`).
- `reset`  in  1  synchronous, active-high reset.
- `serial_clk`  in  1  MCU serial clock (`usart_clk` pin), asynchronous.
- `serial_rxd`  in  1  MCU data line (`usart_tx` pin), asynchronous, idle high.
- `rx_data`  out  8  FIFO head byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ack`  in  1  pop head; ignored when `rx_valid`=0.
- `fill`  out  FIFO_AW+1  current FIFO occupancy.
- `busy`  out  1  deframer not in IDLE.
- `frame_err`  out  1  sticky: bad stop bit or timeout.
- `overflow`  out  1  sticky: byte dropped because the FIFO was full.
- `err_clr`  in  1  clears `frame_err` and `overflow`.

## Operation
- Input conditioning: `serial_clk` and `serial_rxd` each pass through a 2-FF synchronizer. A third register on the synced clock forms the rising-edge strobe `sclk_rise`. All deframer actions happen only on `sclk_rise`, using the synced rxd value as the sample.
- Deframer FSM:
  - IDLE: a sample of 0 is the start bit. Clear the bit counter and go to DATA. A sample of 1 stays in IDLE.
  - DATA: shift the sample into the shift register LSB-first. After the 8th sample, go to STOP.
  - STOP: a sample of 1 pushes the byte and returns to IDLE. A sample of 0 sets `frame_err`, discards the byte and goes to BREAK.
  - BREAK: wait for a sample of 1, then go to IDLE. This prevents a held-low line from producing back-to-back phantom frames.
- Timeout: in DATA, STOP or BREAK, a cycle counter is cleared on every `sclk_rise`. When it reaches TIMEOUT, set `frame_err`, discard the partial byte and force IDLE. The counter is 10 bits wide by default (width = clog2(TIMEOUT+1)) and saturates; it never wraps.
- FIFO: circular buffer with write pointer, read pointer and count. It is show-ahead: `rx_data` = mem[rd_ptr] combinationally from registered storage.
  - Pointers wrap modulo 2**FIFO_AW.
  - `fill` = count, range 0..2**FIFO_AW.
  - Push when full and no pop in the same cycle: the byte is dropped, `overflow` is set, and pointers are unchanged.
  - Push and pop in the same cycle, whether full or not: both are performed, count is unchanged, and `overflow` is not set.
  - Pop when empty: no effect.
- Flags: `err_clr` clears both sticky flags. If a set event and `err_clr` occur in the same cycle, the set wins.
- Reset, including mid-frame: FSM goes to IDLE, shift register and counters to 0, FIFO emptied (pointers and count 0), flags cleared, synchronizers loaded with 1 (idle line, no edge). Stored FIFO contents are not cleared; they are don't-care.

## Timing
- Reset values: `rx_valid`=0, `fill`=0, `busy`=0, `frame_err`=0, `overflow`=0, `rx_data`=don't-care.
- `sclk_rise` is asserted 3 `clk` cycles after the pin rising edge (±1 cycle synchronizer uncertainty). It lasts one cycle per edge.
- The push occurs in the `sclk_rise` cycle of the stop bit. `rx_valid`, `fill` and `rx_data` update on the next `clk` edge.
- Pop: `rx_ack`=1 with `rx_valid`=1 at edge N. The new head or `rx_valid`=0 is visible after edge N.
- `busy` is 1 from the cycle after the start-bit sample until the cycle after the return to IDLE.
- Minimum serial clock period: 8 `clk` cycles (high ≥4, low ≥4). Faster clocks are out of spec.
- One frame = 10 `sclk_rise` events. There is no minimum idle time between frames.

## Test plan
- Single byte: send 0xA5 (bits 0,1,0,1,0,0,1,0,1,1) with a 16-cycle serial period. Required: `rx_valid`=1 with `rx_data`=0xA5, `fill`=1. Pulse `rx_ack`: `rx_valid`=0, `fill`=0.
- Framing error: send 0x3C with stop bit 0, then hold the line 0 for 3 edges, then 1. Required: `frame_err`=1, `fill`=0, no phantom byte. A following 0x55 frame is received correctly. `err_clr` clears the flag.
- Overflow: with `rx_ack`=0, send 0x01..0x05. Required: `fill`=4, `overflow`=1 after the 5th byte. Pops return 0x01,0x02,0x03,0x04, then `rx_valid`=0.
- Simultaneous push/pop at full: fill with 0x10..0x13, then assert `rx_ack` exactly in the stop-bit push cycle of 0x14. Required: `fill` stays 4, `overflow`=0, and the drain order is 0x11,0x12,0x13,0x14.
- Timeout: send a start bit plus 3 data bits, then stop `serial_clk` for 1100 `clk` cycles. Required: `frame_err`=1 at cycle 1023 after the last edge, `busy`=0, `fill`=0. The next full frame 0x7E is received.
- Reset mid-frame: assert `reset` for 1 cycle after 5 data bits with 2 bytes queued. Required: all outputs return to their reset values. A new frame 0xC3 sent from idle is received as the only FIFO entry.
